mdl_comburst_det: RTL and testbench

Bench-model COM burst detector for the device side of the SATA link. It samples the differential receive pair on `i_txclk`, measures the length of each signalling burst and each electrical-idle gap, and classifies runs of qualifying burst/gap pairs as COMRESET/COMINIT or COMWAKE. Its single-cycle `o_comreset` / `o_comwake` pulses feed the device COM handshake FSM, which pipelines them before acting.

---
 rtl/mdl_comburst_det.sv | 179 +++++++++++++++++
 tb/tb_mdl_comburst_det.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdl_comburst_det.sv
// SATA device-side COM burst detector: measures burst/idle run lengths and pulses on COMRESET/COMINIT or COMWAKE.
// Optional build macro MDL_COMDET_DEGLITCH_EN adds a 2-sample line filter (+1 clock on every latency).
module mdl_comburst_det #(
  parameter int BURST_MIN    = 150,
  parameter int BURST_MAX    = 170,
  parameter int WAKE_GAP_MIN = 152,
  parameter int WAKE_GAP_MAX = 168,
  parameter int INIT_GAP_MIN = 456,
  parameter int INIT_GAP_MAX = 504,
  parameter int NUM_GAPS     = 3
) (
  input  logic i_txclk,
  input  logic i_reset,
  input  logic i_rx_p,
  input  logic i_rx_n,
  output logic o_comreset,
  output logic o_comwake,
  output logic o_busy
);

  localparam int CW = $clog2(INIT_GAP_MAX + 2);
  localparam int MW = $clog2(NUM_GAPS + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(INIT_GAP_MAX + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] B_MIN   = CW'(BURST_MIN);
  localparam logic [CW-1:0] B_MAX   = CW'(BURST_MAX);
  localparam logic [CW-1:0] W_MIN   = CW'(WAKE_GAP_MIN);
  localparam logic [CW-1:0] W_MAX   = CW'(WAKE_GAP_MAX);
  localparam logic [CW-1:0] I_MIN   = CW'(INIT_GAP_MIN);
  localparam logic [CW-1:0] I_MAX   = CW'(INIT_GAP_MAX);
  localparam logic [MW-1:0] M_FIRE  = MW'(NUM_GAPS);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;
  typedef enum logic [1:0] {C_NONE, C_WAKE, C_INIT} cls_t;

  logic act;
  logic line_q;
  logic line_vld;
  logic armed;

  // X/Z on either leg must read as idle, hence the case-equality compare.
  assign act = ((i_rx_p ^ i_rx_n) === 1'b1);

`ifdef MDL_COMDET_DEGLITCH_EN
  logic samp_q;
  logic samp_vld;

  always_ff @(posedge i_txclk) begin
    if (i_reset) begin
      samp_q   <= 1'b0;
      samp_vld <= 1'b0;
      line_q   <= 1'b0;
      line_vld <= 1'b0;
    end else begin
      samp_q   <= act;
      samp_vld <= 1'b1;
      if (samp_vld && (act == samp_q)) begin
        line_q   <= act;
        line_vld <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge i_txclk) begin
    if (i_reset) begin
      line_q   <= 1'b0;
      line_vld <= 1'b0;
    end else begin
      line_q   <= act;
      line_vld <= 1'b1;
    end
  end
`endif

  // A burst already in flight at reset release is skipped: IDLE must see a real idle sample first.
  always_ff @(posedge i_txclk) begin
    if (i_reset) armed <= 1'b0;
    else         armed <= armed | (line_vld & ~line_q);
  end

  state_t        state, state_nxt;
  cls_t          cls_q, cls_nxt, gap_cls;
  logic [CW-1:0] burst_cnt, burst_nxt;
  logic [CW-1:0] gap_cnt, gap_nxt;
  logic [MW-1:0] match_cnt, match_nxt;
  logic          bad_q, bad_nxt;
  logic          rst_nxt, wake_nxt, busy_nxt;

  always_ff @(posedge i_txclk) begin
    if (i_reset) begin
      state      <= S_IDLE;
      cls_q      <= C_NONE;
      burst_cnt  <= '0;
      gap_cnt    <= '0;
      match_cnt  <= '0;
      bad_q      <= 1'b0;
      o_comreset <= 1'b0;
      o_comwake  <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cls_q      <= cls_nxt;
      burst_cnt  <= burst_nxt;
      gap_cnt    <= gap_nxt;
      match_cnt  <= match_nxt;
      bad_q      <= bad_nxt;
      o_comreset <= rst_nxt;
      o_comwake  <= wake_nxt;
      o_busy     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cls_nxt   = cls_q;
    burst_nxt = burst_cnt;
    gap_nxt   = gap_cnt;
    match_nxt = match_cnt;
    bad_nxt   = bad_q;
    rst_nxt   = 1'b0;
    wake_nxt  = 1'b0;
    gap_cls   = C_NONE;
    case (state)
      S_IDLE: begin
        match_nxt = '0;
        cls_nxt   = C_NONE;
        bad_nxt   = 1'b0;
        if (armed && line_q) begin
          state_nxt = S_BURST;
          burst_nxt = CNT_ONE;
        end
      end
      S_BURST: begin
        if (line_q) begin
          burst_nxt = (burst_cnt == CNT_SAT) ? burst_cnt : burst_cnt + CNT_ONE;
        end else begin
          state_nxt = S_GAP;
          gap_nxt   = CNT_ONE;
          bad_nxt   = bad_q | (burst_cnt < B_MIN) | (burst_cnt > B_MAX);
        end
      end
      S_GAP: begin
        if (!line_q) begin
          if (gap_cnt > I_MAX) begin
            state_nxt = S_IDLE;
            match_nxt = '0;
            cls_nxt   = C_NONE;
          end else begin
            gap_nxt = (gap_cnt == CNT_SAT) ? gap_cnt : gap_cnt + CNT_ONE;
          end
        end else begin
          if (gap_cnt >= W_MIN && gap_cnt <= W_MAX)      gap_cls = C_WAKE;
          else if (gap_cnt >= I_MIN && gap_cnt <= I_MAX) gap_cls = C_INIT;
          if (bad_q || gap_cls == C_NONE) begin
            match_nxt = '0;
            cls_nxt   = C_NONE;
          end else if (gap_cls == cls_q) begin
            match_nxt = match_cnt + MW'(1);
          end else begin
            match_nxt = MW'(1);
            cls_nxt   = gap_cls;
          end
          // Fire from the updated count in the same cycle so the pulse lands 2 clocks after the line edge.
          if (match_nxt == M_FIRE) begin
            rst_nxt   = (cls_nxt == C_INIT);
            wake_nxt  = (cls_nxt == C_WAKE);
            match_nxt = '0;
          end
          bad_nxt   = 1'b0;
          state_nxt = S_BURST;
          burst_nxt = CNT_ONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt == S_BURST) || (match_nxt != '0);
  end

endmodule

// File: tb/tb_mdl_comburst_det.sv
// Bench for mdl_comburst_det: drives run-length segments and compares pulse times against a run-length model.
module tb_mdl_comburst_det;

  localparam int BURST_MIN    = 150;
  localparam int BURST_MAX    = 170;
  localparam int WAKE_GAP_MIN = 152;
  localparam int WAKE_GAP_MAX = 168;
  localparam int INIT_GAP_MIN = 456;
  localparam int INIT_GAP_MAX = 504;
  localparam int NUM_GAPS     = 3;
`ifdef MDL_COMDET_DEGLITCH_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic i_txclk = 1'b0;
  logic i_reset = 1'b1;
  logic i_rx_p  = 1'b0;
  logic i_rx_n  = 1'b0;
  logic o_comreset, o_comwake, o_busy;

  mdl_comburst_det dut (
    .i_txclk    (i_txclk),
    .i_reset    (i_reset),
    .i_rx_p     (i_rx_p),
    .i_rx_n     (i_rx_n),
    .o_comreset (o_comreset),
    .o_comwake  (o_comwake),
    .o_busy     (o_busy)
  );

  always #5 i_txclk = ~i_txclk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge i_txclk) cyc <= cyc + 1;

  int got_rst[$], got_wake[$];
  int exp_rst[$], exp_wake[$];
  int seg_lvl[$], seg_len[$], seg_t0[$];

  always @(negedge i_txclk) begin
    if (o_comreset) got_rst.push_back(cyc);
    if (o_comwake)  got_wake.push_back(cyc);
    if (o_comreset || o_comwake) begin
      vectors++;
      assert (!(o_comreset && o_comwake)) else begin
        miscompares++;
        $error("FAIL both_pulses at cycle %0d: observed both high, expected at most one", cyc);
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic add(input int lvl, input int len);
    seg_lvl.push_back(lvl);
    seg_len.push_back(len);
  endtask

  task automatic clear_segs();
    seg_lvl.delete();
    seg_len.delete();
    seg_t0.delete();
  endtask

  // Called at a negedge; each segment holds the pair for len clocks.
  task automatic drive();
    logic idle_lvl;
    seg_t0.delete();
    for (int i = 0; i < seg_lvl.size(); i++) begin
      idle_lvl = 1'($urandom_range(0, 1));
      i_rx_p = seg_lvl[i] ? 1'b1 : idle_lvl;
      i_rx_n = seg_lvl[i] ? 1'b0 : idle_lvl;
      seg_t0.push_back(cyc);
      repeat (seg_len[i]) @(negedge i_txclk);
    end
  endtask

  // Reference: walks burst/gap run lengths and applies the classify/match/fire rules directly.
  task automatic model();
    int lv[$], ln[$], t0[$];
    int cnt, cls, gcls, k;
    bit in_seq, prev_ok;
    exp_rst.delete();
    exp_wake.delete();
    lv = seg_lvl;
    ln = seg_len;
    t0 = seg_t0;
`ifdef MDL_COMDET_DEGLITCH_EN
    k = 1;
    while (k < lv.size() - 1) begin
      if (ln[k] == 1) begin
        ln[k-1] += 1 + ln[k+1];
        ln.delete(k+1); ln.delete(k);
        lv.delete(k+1); lv.delete(k);
        t0.delete(k+1); t0.delete(k);
      end else k++;
    end
`else
    k = 0;
`endif
    in_seq = 0; prev_ok = 0; cnt = 0; cls = 0; gcls = 0;
    for (int i = 0; i < lv.size(); i++) begin
      if (lv[i] != 0) begin
        if (in_seq) begin
          if (!prev_ok || gcls == 0) begin cnt = 0; cls = 0; end
          else if (gcls == cls) cnt++;
          else begin cnt = 1; cls = gcls; end
          if (cnt == NUM_GAPS) begin
            if (cls == 2) exp_rst.push_back(t0[i] + LAT);
            else          exp_wake.push_back(t0[i] + LAT);
            cnt = 0;
          end
        end
        in_seq  = 1;
        prev_ok = (ln[i] >= BURST_MIN) && (ln[i] <= BURST_MAX);
      end else if (in_seq) begin
        if (ln[i] > INIT_GAP_MAX) begin
          in_seq = 0; cnt = 0; cls = 0;
        end else if (ln[i] >= WAKE_GAP_MIN && ln[i] <= WAKE_GAP_MAX) gcls = 1;
        else if (ln[i] >= INIT_GAP_MIN && ln[i] <= INIT_GAP_MAX) gcls = 2;
        else gcls = 0;
      end
    end
  endtask

  task automatic run_scn(input string tag);
    got_rst.delete();
    got_wake.delete();
    drive();
    model();
    chk({tag, " n_comreset"}, got_rst.size(), exp_rst.size());
    chk({tag, " n_comwake"}, got_wake.size(), exp_wake.size());
    for (int i = 0; i < got_rst.size() && i < exp_rst.size(); i++)
      chk({tag, " t_comreset"}, got_rst[i], exp_rst[i]);
    for (int i = 0; i < got_wake.size() && i < exp_wake.size(); i++)
      chk({tag, " t_comwake"}, got_wake[i], exp_wake[i]);
    chk({tag, " busy_end"}, int'(o_busy), 0);
  endtask

  task automatic train(input int nb, input int blen, input int glen);
    clear_segs();
    add(0, 20);
    for (int i = 0; i < nb; i++) begin
      add(1, blen);
      add(0, (i == nb - 1) ? 600 : glen);
    end
  endtask

  int btab[5] = '{149, 150, 160, 170, 171};
  int gtab[9] = '{151, 152, 160, 168, 169, 455, 456, 480, 504};

  initial begin
    repeat (3) @(negedge i_txclk);
    chk("reset comreset", int'(o_comreset), 0);
    chk("reset comwake", int'(o_comwake), 0);
    chk("reset busy", int'(o_busy), 0);
    i_reset = 1'b0;

    train(6, 160, 480);
    run_scn("comreset6");
    chk("comreset6 single", got_rst.size(), 1);

    train(6, 160, 160);
    run_scn("comwake6");

    clear_segs();
    add(0, 20);
    add(1, 150); add(0, 152); add(1, 170); add(0, 168);
    add(1, 160); add(0, 152); add(1, 160); add(0, 600);
    run_scn("wake_bounds");

    train(4, 160, 151);
    run_scn("gap151");

    clear_segs();
    add(0, 20);
    add(1, 160); add(0, 456); add(1, 160); add(0, 504);
    add(1, 160); add(0, 480); add(1, 160); add(0, 600);
    run_scn("init_bounds");

    clear_segs();
    add(0, 20);
    for (int i = 0; i < 7; i++) begin
      add(1, (i == 2) ? 171 : 160);
      add(0, (i == 6) ? 600 : 160);
    end
    run_scn("bad_burst");

    clear_segs();
    add(0, 20);
    add(1, 160); add(0, 480); add(1, 160); add(0, 480);
    add(1, 160); add(0, 160); add(1, 160); add(0, 160);
    add(1, 160); add(0, 160); add(1, 160); add(0, 600);
    run_scn("mixed");

    // Reset during the 3rd burst of a COMRESET: nothing from that sequence may fire.
    got_rst.delete();
    got_wake.delete();
    clear_segs();
    add(0, 20);
    add(1, 160); add(0, 480); add(1, 160); add(0, 480); add(1, 80);
    drive();
    chk("midburst busy", int'(o_busy), 1);
    i_reset = 1'b1;
    @(negedge i_txclk);
    i_reset = 1'b0;
    chk("postreset comreset", int'(o_comreset), 0);
    chk("postreset comwake", int'(o_comwake), 0);
    chk("postreset busy", int'(o_busy), 0);
    clear_segs();
    add(1, 79); add(0, 480); add(1, 160); add(0, 600);
    drive();
    chk("midreset n_comreset", got_rst.size(), 0);
    chk("midreset n_comwake", got_wake.size(), 0);

    train(4, 160, 480);
    run_scn("fresh_comreset");

    clear_segs();
    add(0, 20);
    for (int i = 0; i < 4; i++) begin
      add(1, 80); add(0, 1); add(1, 79);
      add(0, (i == 3) ? 600 : 480);
    end
    run_scn("glitch");

    for (int r = 0; r < 6; r++) begin
      int nb;
      nb = int'($urandom_range(2, 6));
      clear_segs();
      add(0, 20);
      for (int i = 0; i < nb; i++) begin
        add(1, btab[$urandom_range(0, 4)]);
        add(0, (i == nb - 1) ? 600 : gtab[$urandom_range(0, 8)]);
      end
      run_scn($sformatf("random%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
